wbc_ram_port: RTL
=================

# wbc_ram_port

Wishbone classic slave front-end for the 8K-word LUT RAM. Sits directly upstream of the RAM: takes single Wishbone cycles from the VM1 bus, drives the RAM's registered-address/delayed-write port with correct timing, returns read data and a registered `wb_ack_o`. Optionally decodes the address window and signals `wb_err_o` for out-of-range accesses.

## Interface
- `RAM_AW`, 13: RAM word-address width.
- `BASE_ADDR`, 16'h0000: window base; only bits [15:RAM_AW+1] are compared.
- `WAIT_CYCLES`, 0: extra wait states inserted before ack (0..15).

- `wb_clk_i`  in  1  clock; also drives the RAM's `clka`.
- `wb_rst_n`  in  1  asynchronous, active-low reset.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1  Wishbone cycle, strobe, write enable.
- `wb_adr_i`  in  16  byte address; bit 0 ignored.
- `wb_dat_i`  in  16  write data.
- `wb_sel_i`  in  2  byte selects: [0] low byte, [1] high byte.
- `wb_dat_o`  out  16  read data, registered.
- `wb_ack_o`  out  1  registered acknowledge.
- `wb_err_o`  out  1  registered error; tied 0 without the macro.
- `ram_addr`  out  RAM_AW  to RAM `addra` = `wb_adr_i[RAM_AW:1]`.
- `ram_din`  out  16  to RAM `dina` = `wb_dat_i`.
- `ram_we`  out  1  to RAM `wea`.
- `ram_byteena`  out  2  to RAM `byteena` = `wb_sel_i`.
- `ram_dout`  in  16  from RAM `douta`.

## Operation
- FSM states: IDLE, DATA, WAIT, ACK.
- IDLE: on `wb_cyc_i & wb_stb_i` -> DATA. `ram_we` = `wb_cyc_i & wb_stb_i & wb_we_i & hit` in IDLE only, 0 in all other states, so exactly one write pulse per cycle.
- DATA: the RAM has latched the address and write enables. If `WAIT_CYCLES`=0: register `ram_dout` into `wb_dat_o` (reads only), set `wb_ack_o` (or `wb_err_o` on a miss) -> ACK. Otherwise load the wait counter with `WAIT_CYCLES`-1 -> WAIT.
- WAIT: decrement; at 0, do the DATA capture -> ACK.
- ACK: ack/err high for exactly one cycle; -> IDLE and clear ack/err.
- The master holds `wb_adr_i`, `wb_dat_i`, `wb_sel_i` stable until ack. The RAM samples `dina` one edge after the address, so the write commits at the DATA-exit edge.
- `wb_dat_o` holds the last read value across writes and idle cycles.
- Abort: `wb_cyc_i` low in DATA/WAIT -> IDLE with no ack. A write already latched by the RAM still commits. This is allowed.
- `wb_sel_i`=2'b00 write: the cycle is acked and memory is unchanged.
- Reset (async): state IDLE, `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=16'h0000, counter 0, `ram_we`=0. A write already latched in the RAM's own (unreset) register may still commit once. Verification accepts that write.

## Timing
- Cycle 0: strobe seen in IDLE.
- Edge 1: RAM latches; state -> DATA.
- Edge 2 + `WAIT_CYCLES`: data captured and ack registered.
- `wb_ack_o` is visible in cycle 2 + `WAIT_CYCLES`.
- Throughput: one access per 3 + `WAIT_CYCLES` cycles. The earliest next strobe is sampled in the cycle after ack.
- Read data is valid in the same cycle as `wb_ack_o`.
- `ram_addr`, `ram_din`, `ram_byteena` are combinational pass-through. `ram_we` is combinational from state and bus inputs.

## Configuration
- `WBC_RAM_PORT_ERR_EN` defined: `hit` = (`wb_adr_i[15:RAM_AW+1]` == `BASE_ADDR[15:RAM_AW+1]`). On a miss: no `ram_we`, `wb_dat_o` unchanged, `wb_err_o` pulses instead of `wb_ack_o`, with the same latency.
- Macro undefined: `hit`=1, upper address bits are ignored (RAM aliases across the full 64KB space), and `wb_err_o`=0.

## Structure
- Package `wbc_ram_pkg`: state enum encoding (IDLE=0, DATA=1, WAIT=2, ACK=3), default `RAM_AW`, and the wait-counter width constant (4).
- Single module; no sub-module. The wait counter is inline.

## Test plan
1. Write 16'hA5C3 to byte address 16'h0010 with sel=2'b11, then read 16'h0010: `wb_ack_o` asserts in cycle 2 of each access and the read returns 16'hA5C3.
2. Write 16'h1234 with sel=2'b01 over existing 16'hFFFF at 16'h0020, then read: returns 16'hFF34. A second write of 16'hABCD with sel=2'b10 then reads back 16'hAB34.
3. `WAIT_CYCLES`=3: a read of a preloaded word acks in cycle 5 with correct data, and `wb_ack_o` is high for exactly 1 cycle.
4. With `WBC_RAM_PORT_ERR_EN` and `BASE_ADDR`=0: write to 16'h4000 gives `wb_err_o` in cycle 2, no `wb_ack_o`, and a read of 16'h0000 is unchanged. Without the macro, the same write acks and lands at word 0.
5. Back-to-back reads of 0x0000/0x0002/0x0004 with stb held high: acks arrive every 3 cycles with data matching the preload file.
6. Assert `wb_rst_n` low in the DATA state of a read: `wb_ack_o`, `wb_err_o`=0 and `wb_dat_o`=16'h0000 immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/wbc_ram_pkg.sv
// Shared types and constants for the Wishbone classic front-end of the LUT RAM.
package wbc_ram_pkg;

    localparam int RAM_AW_DEF = 13;
    localparam int WAIT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

endpackage

// File: rtl/wbc_ram_port.sv
// Wishbone classic slave driving a registered-address / delayed-write LUT RAM port.
// Optional address-window decode with wb_err_o: define WBC_RAM_PORT_ERR_EN.
module wbc_ram_port
    import wbc_ram_pkg::*;
#(
    parameter int          RAM_AW      = RAM_AW_DEF,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [15:0]       wb_adr_i,
    input  logic [15:0]       wb_dat_i,
    input  logic [1:0]        wb_sel_i,
    output logic [15:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_din,
    output logic              ram_we,
    output logic [1:0]        ram_byteena,
    input  logic [15:0]       ram_dout
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        WAIT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_ack;
    logic              r_err;
    logic [15:0]       r_dat;

    logic w_req;
    logic w_hit;
    logic w_capture;

`ifdef WBC_RAM_PORT_ERR_EN
    assign w_hit = (wb_adr_i[15:RAM_AW+1] == BASE_ADDR[15:RAM_AW+1]);
    wire w_unused = wb_adr_i[0];
`else
    // Upper address bits are ignored so the RAM aliases across the whole space.
    assign w_hit = 1'b1;
    wire w_unused = &{1'b0, wb_adr_i[0], wb_adr_i[15:RAM_AW+1]};
`endif

    assign w_req = wb_cyc_i & wb_stb_i;

    // The RAM latched the address on the IDLE->DATA edge; its output is valid from DATA on.
    assign w_capture = ((r_state == ST_DATA) && (WAIT_CYCLES == 0)) ||
                       ((r_state == ST_WAIT) && (r_wait_cnt == '0));

    assign ram_addr    = wb_adr_i[RAM_AW:1];
    assign ram_din     = wb_dat_i;
    assign ram_byteena = wb_sel_i;
    // Only IDLE may raise the write enable, giving exactly one pulse per bus cycle.
    assign ram_we      = (r_state == ST_IDLE) & w_req & wb_we_i & w_hit;

    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) r_state <= ST_DATA;
                end
                ST_DATA, ST_WAIT: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_capture) begin
                        r_state <= ST_ACK;
                        if (w_hit) begin
                            r_ack <= 1'b1;
                            if (!wb_we_i) r_dat <= ram_dout;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (r_state == ST_DATA) begin
                        r_wait_cnt <= WAIT_LOAD;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;

endmodule
